// File: rtl/id_regfile_sb_if.sv
// ID-stage register file bus: read ports, WB write port, scoreboard control.
// The master drives addresses and control; the slave is the register file.
interface id_regfile_sb_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int NUM_READ   = 2
);
   logic [NUM_READ*ADDR_WIDTH-1:0] Read_Address_ID;
   logic [NUM_READ*DATA_WIDTH-1:0] Read_Data_ID;
   logic [NUM_READ-1:0]            Busy_ID;
   logic [ADDR_WIDTH-1:0]          Write_Register_WB;
   logic [DATA_WIDTH-1:0]          Write_Data_WB;
   logic                           RegWrite_WB;
   logic                           Issue_Valid_ID;
   logic [ADDR_WIDTH-1:0]          Issue_Dest_ID;
   logic                           Flush_Pending;
   logic [ADDR_WIDTH:0]            Pending_Count;

   modport master (
      output Read_Address_ID,
      output Write_Register_WB,
      output Write_Data_WB,
      output RegWrite_WB,
      output Issue_Valid_ID,
      output Issue_Dest_ID,
      output Flush_Pending,
      input  Read_Data_ID,
      input  Busy_ID,
      input  Pending_Count
   );

   modport slave (
      input  Read_Address_ID,
      input  Write_Register_WB,
      input  Write_Data_WB,
      input  RegWrite_WB,
      input  Issue_Valid_ID,
      input  Issue_Dest_ID,
      input  Flush_Pending,
      output Read_Data_ID,
      output Busy_ID,
      output Pending_Count
   );
endinterface

// File: rtl/id_regfile_sb.sv
// ID-stage GPR file with WB write bypass and a pending-write scoreboard
// that flags read-after-write hazards to the hazard unit.
module id_regfile_sb #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int NUM_READ   = 2,
   parameter bit BYPASS     = 1'b1,
   parameter bit ZERO_REG   = 1'b1
) (
   input logic            Clk,
   input logic            Rst_n,
   id_regfile_sb_if.slave bus
);
   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam int CW    = ADDR_WIDTH + 1;

   logic [DATA_WIDTH-1:0] regs [DEPTH];
   logic [DEPTH-1:0]      pend;
   logic [DEPTH-1:0]      pend_nxt;
   logic [CW-1:0]         count_q;
   logic [CW-1:0]         count_nxt;
   logic                  wr_en;
   logic                  set_en;

   // Writes to r0 are dropped when it is hardwired; r0 is never pending then.
   assign wr_en  = bus.RegWrite_WB &&
                   !(ZERO_REG && bus.Write_Register_WB == '0);
   assign set_en = bus.Issue_Valid_ID &&
                   !(ZERO_REG && bus.Issue_Dest_ID == '0);

   // Register storage, written from WB.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs[i] <= '0;
         end
      end else if (wr_en) begin
         regs[bus.Write_Register_WB] <= bus.Write_Data_WB;
      end
   end

   // Next pending vector: flush wins, then clear, then set (new producer).
   always_comb begin
      pend_nxt = pend;
      if (bus.Flush_Pending) begin
         pend_nxt = '0;
      end else begin
         if (bus.RegWrite_WB) begin
            pend_nxt[bus.Write_Register_WB] = 1'b0;
         end
         if (set_en) begin
            pend_nxt[bus.Issue_Dest_ID] = 1'b1;
         end
      end
      if (ZERO_REG) begin
         pend_nxt[0] = 1'b0;
      end
   end

   // Population count of the next pending vector, registered with the bits.
   always_comb begin
      count_nxt = '0;
      for (int i = 0; i < DEPTH; i++) begin
         count_nxt = count_nxt + CW'(pend_nxt[i]);
      end
   end

   // Pending bits and their count share one edge.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         pend    <= '0;
         count_q <= '0;
      end else begin
         pend    <= pend_nxt;
         count_q <= count_nxt;
      end
   end

   assign bus.Pending_Count = count_q;

   // Combinational read ports with optional WB bypass; forced to 0 in reset.
   always_comb begin
      logic [ADDR_WIDTH-1:0] a;
      logic                  hit;
      bus.Read_Data_ID = '0;
      bus.Busy_ID      = '0;
      for (int k = 0; k < NUM_READ; k++) begin
         a   = bus.Read_Address_ID[k*ADDR_WIDTH +: ADDR_WIDTH];
         hit = BYPASS && bus.RegWrite_WB &&
               bus.Write_Register_WB == a;
         if (!Rst_n || (ZERO_REG && a == '0)) begin
            bus.Read_Data_ID[k*DATA_WIDTH +: DATA_WIDTH] = '0;
            bus.Busy_ID[k] = 1'b0;
         end else begin
            bus.Read_Data_ID[k*DATA_WIDTH +: DATA_WIDTH] =
               hit ? bus.Write_Data_WB : regs[a];
            bus.Busy_ID[k] = pend[a] && !hit;
         end
      end
   end
endmodule

// File: tb/tb_id_regfile_sb.sv
// Bench for id_regfile_sb: a bypassing and a non-bypassing instance share
// stimulus; expectations are queued and checked by a negedge monitor.
module tb_id_regfile_sb;
   localparam int DW = 32;
   localparam int AW = 5;
   localparam int NR = 2;

   localparam int K_RD0   = 0;
   localparam int K_RD1   = 1;
   localparam int K_BUSY  = 2;
   localparam int K_CNT   = 3;
   localparam int K_NRD0  = 4;
   localparam int K_NRD1  = 5;
   localparam int K_NBUSY = 6;
   localparam int K_NCNT  = 7;

   logic Clk = 1'b0;
   logic Rst_n = 1'b0;

   always #5 Clk = ~Clk;

   id_regfile_sb_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR)) bus0 ();
   id_regfile_sb_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR)) bus1 ();

   assign bus1.Read_Address_ID   = bus0.Read_Address_ID;
   assign bus1.Write_Register_WB = bus0.Write_Register_WB;
   assign bus1.Write_Data_WB     = bus0.Write_Data_WB;
   assign bus1.RegWrite_WB       = bus0.RegWrite_WB;
   assign bus1.Issue_Valid_ID    = bus0.Issue_Valid_ID;
   assign bus1.Issue_Dest_ID     = bus0.Issue_Dest_ID;
   assign bus1.Flush_Pending     = bus0.Flush_Pending;

   id_regfile_sb #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR),
      .BYPASS(1'b1), .ZERO_REG(1'b1)
   ) u_dut (
      .Clk(Clk), .Rst_n(Rst_n), .bus(bus0.slave)
   );

   id_regfile_sb #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR),
      .BYPASS(1'b0), .ZERO_REG(1'b1)
   ) u_dut_nb (
      .Clk(Clk), .Rst_n(Rst_n), .bus(bus1.slave)
   );

   typedef struct {
      string       name;
      int          kind;
      logic [31:0] exp;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_fail = 0;

   function automatic logic [31:0] observe(input int k);
      case (k)
         K_RD0:   return bus0.Read_Data_ID[31:0];
         K_RD1:   return bus0.Read_Data_ID[63:32];
         K_BUSY:  return {30'd0, bus0.Busy_ID};
         K_CNT:   return {26'd0, bus0.Pending_Count};
         K_NRD0:  return bus1.Read_Data_ID[31:0];
         K_NRD1:  return bus1.Read_Data_ID[63:32];
         K_NBUSY: return {30'd0, bus1.Busy_ID};
         K_NCNT:  return {26'd0, bus1.Pending_Count};
         default: return 32'hxxxx_xxxx;
      endcase
   endfunction

   // Monitor: every negedge, compare all outstanding expectations.
   always @(negedge Clk) begin : mon
      exp_t        e;
      logic [31:0] act;
      while (q.size() > 0) begin
         e   = q.pop_front();
         act = observe(e.kind);
         n_checks++;
         if (act !== e.exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
         end
      end
   end

   task automatic chk(input string n, input int k, input logic [31:0] v);
      exp_t e;
      e.name = n;
      e.kind = k;
      e.exp  = v;
      q.push_back(e);
   endtask

   task automatic cyc();
      @(posedge Clk);
      #1;
      bus0.RegWrite_WB    = 1'b0;
      bus0.Issue_Valid_ID = 1'b0;
      bus0.Flush_Pending  = 1'b0;
   endtask

   task automatic rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
      bus0.Read_Address_ID = {a1, a0};
   endtask

   task automatic wb(input logic [AW-1:0] a, input logic [DW-1:0] d);
      bus0.RegWrite_WB       = 1'b1;
      bus0.Write_Register_WB = a;
      bus0.Write_Data_WB     = d;
   endtask

   task automatic iss(input logic [AW-1:0] a);
      bus0.Issue_Valid_ID = 1'b1;
      bus0.Issue_Dest_ID  = a;
   endtask

   initial begin
      bus0.Read_Address_ID   = '0;
      bus0.Write_Register_WB = '0;
      bus0.Write_Data_WB     = '0;
      bus0.RegWrite_WB       = 1'b0;
      bus0.Issue_Valid_ID    = 1'b0;
      bus0.Issue_Dest_ID     = '0;
      bus0.Flush_Pending     = 1'b0;

      cyc();
      rd(5, 31);
      chk("rst_rd0", K_RD0, 0);
      chk("rst_rd1", K_RD1, 0);
      chk("rst_busy", K_BUSY, 0);
      chk("rst_cnt", K_CNT, 0);

      cyc();
      Rst_n = 1'b1;
      rd(0, 31);
      chk("post_rd0", K_RD0, 0);
      chk("post_rd1", K_RD1, 0);
      chk("post_busy", K_BUSY, 0);
      chk("post_cnt", K_CNT, 0);

      cyc();
      wb(5, 32'hDEAD_BEEF);
      rd(0, 31);
      chk("wr5_r0", K_RD0, 0);

      cyc();
      wb(0, 32'h0000_1234);
      rd(5, 0);
      chk("rd_r5", K_RD0, 32'hDEAD_BEEF);
      chk("rd_r5_nb", K_NRD0, 32'hDEAD_BEEF);
      chk("r0_wr_nobyp", K_RD1, 0);

      cyc();
      wb(7, 32'hA5A5_A5A5);
      rd(0, 7);
      chk("r0_after_wr", K_RD0, 0);
      chk("byp_r7", K_RD1, 32'hA5A5_A5A5);
      chk("nobyp_r7_old", K_NRD1, 0);

      cyc();
      rd(0, 7);
      chk("r7_next", K_RD1, 32'hA5A5_A5A5);
      chk("nobyp_r7_new", K_NRD1, 32'hA5A5_A5A5);

      cyc();
      iss(9);
      rd(9, 7);
      chk("iss9_busy", K_BUSY, 0);
      chk("iss9_cnt", K_CNT, 0);

      cyc();
      rd(9, 7);
      chk("pend9_busy", K_BUSY, 1);
      chk("pend9_cnt", K_CNT, 1);
      chk("pend9_busy_nb", K_NBUSY, 1);

      cyc();
      wb(9, 32'h0000_0099);
      rd(9, 7);
      chk("wb9_busy", K_BUSY, 0);
      chk("wb9_busy_nb", K_NBUSY, 1);
      chk("wb9_rd", K_RD0, 32'h99);
      chk("wb9_rd_nb", K_NRD0, 0);
      chk("wb9_cnt", K_CNT, 1);

      cyc();
      rd(9, 7);
      chk("clr9_busy", K_BUSY, 0);
      chk("clr9_busy_nb", K_NBUSY, 0);
      chk("clr9_cnt", K_CNT, 0);
      chk("clr9_cnt_nb", K_NCNT, 0);
      chk("clr9_rd", K_RD0, 32'h99);

      cyc();
      iss(3);
      rd(3, 7);
      chk("iss3_cnt", K_CNT, 0);

      cyc();
      iss(3);
      wb(3, 32'h0000_0033);
      rd(3, 7);
      chk("setclr3_busy", K_BUSY, 0);
      chk("setclr3_busy_nb", K_NBUSY, 1);
      chk("setclr3_cnt", K_CNT, 1);

      cyc();
      rd(3, 7);
      chk("r3_still_busy", K_BUSY, 1);
      chk("r3_cnt", K_CNT, 1);
      chk("r3_rd", K_RD0, 32'h33);

      cyc();
      iss(0);
      rd(0, 3);
      chk("iss0_busy", K_BUSY, 2);
      chk("iss0_cnt", K_CNT, 1);

      cyc();
      rd(0, 3);
      chk("iss0_busy_after", K_BUSY, 2);
      chk("iss0_cnt_after", K_CNT, 1);

      cyc();
      iss(4);
      rd(4, 6);
      chk("iss4_busy", K_BUSY, 0);

      cyc();
      iss(6);
      bus0.Flush_Pending = 1'b1;
      rd(4, 6);
      chk("flush_busy_pre", K_BUSY, 1);
      chk("flush_cnt_pre", K_CNT, 2);

      cyc();
      rd(4, 6);
      chk("flush_busy", K_BUSY, 0);
      chk("flush_cnt", K_CNT, 0);
      chk("flush_cnt_nb", K_NCNT, 0);

      cyc();
      iss(1);
      wb(1, 32'h0000_0055);
      rd(1, 2);

      cyc();
      iss(2);
      rd(1, 2);
      chk("r1_busy", K_BUSY, 1);
      chk("r1_rd", K_RD0, 32'h55);

      cyc();
      rd(1, 2);
      chk("r12_busy", K_BUSY, 3);
      chk("r12_cnt", K_CNT, 2);
      chk("r12_rd", K_RD0, 32'h55);

      cyc();
      Rst_n = 1'b0;
      chk("arst_rd0", K_RD0, 0);
      chk("arst_busy", K_BUSY, 0);
      chk("arst_cnt", K_CNT, 0);
      chk("arst_cnt_nb", K_NCNT, 0);

      cyc();
      Rst_n = 1'b1;
      rd(1, 2);
      chk("rel_rd0", K_RD0, 0);
      chk("rel_busy", K_BUSY, 0);
      chk("rel_cnt", K_CNT, 0);

      cyc();
      chk("rel_cnt2", K_CNT, 0);
      chk("rel_rd0_nb", K_NRD0, 0);

      for (int i = 0; i < 10 && q.size() > 0; i++) begin
         @(negedge Clk);
      end
      #1;
      if (q.size() > 0) begin
         n_fail++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end
endmodule
